// File: rtl/stopwatch_upcounter_pkg.sv
// Shared definitions for the MM:SS stopwatch: FSM state encoding and BCD digit limits.
// Also holds the digit range helper used by every counter stage.
package stopwatch_upcounter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } sw_state_e;

    localparam logic [3:0] ONES_LIMIT = 4'd9;
    localparam logic [3:0] TENS_LIMIT = 4'd5;

    // True when a digit value lies within 0..limit, i.e. a legal display value.
    function automatic logic digit_in_range(input logic [3:0] value, input logic [3:0] limit);
        return (value <= limit);
    endfunction

endpackage

// File: rtl/stopwatch_upcounter_if.sv
// Control strobes and display outputs of the stopwatch, grouped as one bundle.
// master drives the strobes and observes the display; slave is the stopwatch itself.
interface stopwatch_upcounter_if;

    logic       tick;
    logic       start_pause;
    logic       clear;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       running;
    logic       done;
    logic       carry_out;

    modport master (
        output tick, start_pause, clear,
        input  sec_ones, sec_tens, min_ones, min_tens, running, done, carry_out
    );

    modport slave (
        input  tick, start_pause, clear,
        output sec_ones, sec_tens, min_ones, min_tens, running, done, carry_out
    );

endinterface

// File: rtl/stopwatch_upcounter_upcounter.sv
// One BCD digit stage: counts on increase, rolls over at limit and raises carry in that cycle.
// Knows nothing about stopwatch states; clear is a synchronous return to zero.
module upcounter
    import stopwatch_upcounter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       increase,
    input  logic [3:0] limit,
    output logic [3:0] value,
    output logic       carry
);

    logic [3:0] value_r;
    logic [3:0] value_next_s;
    logic       at_limit_s;

    // >= rather than == so a corrupted value still rolls back to zero instead of running on.
    assign at_limit_s = (value_r >= limit);
    assign carry      = increase & at_limit_s;
    assign value      = value_r;

    // Next digit value: clear wins, then count, then scrub any out-of-range value.
    always_comb begin
        value_next_s = value_r;
        if (clear) begin
            value_next_s = 4'd0;
        end else if (increase) begin
            if (at_limit_s) begin
                value_next_s = 4'd0;
            end else begin
                value_next_s = value_r + 4'd1;
            end
        end else if (!digit_in_range(value_r, limit)) begin
            value_next_s = 4'd0;
        end else begin
            value_next_s = value_r;
        end
    end

    // Digit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_r <= 4'd0;
        end else begin
            value_r <= value_next_s;
        end
    end

endmodule

// File: rtl/stopwatch_upcounter.sv
// MM:SS stopwatch: run/pause/done FSM driving a four-stage BCD ripple-carry counter.
// WRAP selects rollover at 59:59 or a hold in DONE until clear.
module stopwatch_upcounter
    import stopwatch_upcounter_pkg::*;
#(
    parameter bit WRAP = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    stopwatch_upcounter_if.slave bus
);

    sw_state_e  state_r;
    sw_state_e  state_next_s;
    logic       running_r;
    logic       done_r;

    logic [3:0] sec_ones_s;
    logic [3:0] sec_tens_s;
    logic [3:0] min_ones_s;
    logic [3:0] min_tens_s;
    logic       sec_ones_carry_s;
    logic       sec_tens_carry_s;
    logic       min_ones_carry_s;
    logic       min_tens_carry_s;

    logic       counted_s;
    logic       at_max_s;
    logic       hold_s;
    logic       increase_s;

    // A tick only counts in RUN, and clear in the same cycle cancels it.
    assign counted_s  = bus.tick & (state_r == ST_RUN) & ~bus.clear;
    assign at_max_s   = (min_tens_s == TENS_LIMIT) && (min_ones_s == ONES_LIMIT) &&
                        (sec_tens_s == TENS_LIMIT) && (sec_ones_s == ONES_LIMIT);
    assign hold_s     = (WRAP == 1'b0) & at_max_s;
    assign increase_s = counted_s & ~hold_s;

    upcounter u_sec_ones (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (bus.clear),
        .increase (increase_s),
        .limit    (ONES_LIMIT),
        .value    (sec_ones_s),
        .carry    (sec_ones_carry_s)
    );

    upcounter u_sec_tens (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (bus.clear),
        .increase (sec_ones_carry_s),
        .limit    (TENS_LIMIT),
        .value    (sec_tens_s),
        .carry    (sec_tens_carry_s)
    );

    upcounter u_min_ones (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (bus.clear),
        .increase (sec_tens_carry_s),
        .limit    (ONES_LIMIT),
        .value    (min_ones_s),
        .carry    (min_ones_carry_s)
    );

    upcounter u_min_tens (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (bus.clear),
        .increase (min_ones_carry_s),
        .limit    (TENS_LIMIT),
        .value    (min_tens_s),
        .carry    (min_tens_carry_s)
    );

    // Next state: clear overrides everything; reaching 59:59 without WRAP beats a pause request.
    always_comb begin
        state_next_s = state_r;
        if (bus.clear) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start_pause) begin
                        state_next_s = ST_RUN;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (counted_s && hold_s) begin
                        state_next_s = ST_DONE;
                    end else if (bus.start_pause) begin
                        state_next_s = ST_PAUSE;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end
                ST_PAUSE: begin
                    if (bus.start_pause) begin
                        state_next_s = ST_RUN;
                    end else begin
                        state_next_s = ST_PAUSE;
                    end
                end
                ST_DONE: begin
                    state_next_s = ST_DONE;
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // State register with status flags registered alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            running_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            running_r <= (state_next_s == ST_RUN);
            done_r    <= (state_next_s == ST_DONE);
        end
    end

    assign bus.sec_ones  = sec_ones_s;
    assign bus.sec_tens  = sec_tens_s;
    assign bus.min_ones  = min_ones_s;
    assign bus.min_tens  = min_tens_s;
    assign bus.running   = running_r;
    assign bus.done      = done_r;
    // With WRAP the chain's top carry is the rollover; without it the chain is frozen at 59:59.
    assign bus.carry_out = min_tens_carry_s | (counted_s & hold_s);

endmodule

// File: tb/tb_stopwatch_upcounter.sv
// Directed bench for stopwatch_upcounter: one WRAP=1 and one WRAP=0 instance on shared stimulus.
module tb_stopwatch_upcounter;

    logic clk;
    logic rst_n;
    logic tick;
    logic sp;
    logic clr;
    int   total;
    int   bad;
    int   cc1;
    int   cc0;

    stopwatch_upcounter_if if_w1 ();
    stopwatch_upcounter_if if_w0 ();

    assign if_w1.tick        = tick;
    assign if_w1.start_pause = sp;
    assign if_w1.clear       = clr;
    assign if_w0.tick        = tick;
    assign if_w0.start_pause = sp;
    assign if_w0.clear       = clr;

    stopwatch_upcounter #(.WRAP(1'b1)) dut_w1 (.clk(clk), .rst_n(rst_n), .bus(if_w1));
    stopwatch_upcounter #(.WRAP(1'b0)) dut_w0 (.clk(clk), .rst_n(rst_n), .bus(if_w0));

    wire [15:0] d1 = {if_w1.min_tens, if_w1.min_ones, if_w1.sec_tens, if_w1.sec_ones};
    wire [15:0] d0 = {if_w0.min_tens, if_w0.min_ones, if_w0.sec_tens, if_w0.sec_ones};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle of stimulus, entered and left 1 time unit after a rising edge.
    task automatic pulse(input logic t, input logic s, input logic c);
        tick = t;
        sp   = s;
        clr  = c;
        #3;
        cc1 += int'(if_w1.carry_out);
        cc0 += int'(if_w0.carry_out);
        @(posedge clk);
        #1;
        tick = 1'b0;
        sp   = 1'b0;
        clr  = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0; cc1 = 0; cc0 = 0;
        rst_n = 1'b0; tick = 1'b0; sp = 1'b0; clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_digits_w1", 32'(d1), 32'h0000);
        check_val("rst_digits_w0", 32'(d0), 32'h0000);
        check_val("rst_running",   32'(if_w1.running), 32'd0);
        check_val("rst_done",      32'(if_w0.done), 32'd0);
        check_val("rst_carry",     32'(if_w1.carry_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Start and count 61 seconds.
        pulse(1'b0, 1'b1, 1'b0);
        check_val("start_running", 32'(if_w1.running), 32'd1);
        repeat (61) pulse(1'b1, 1'b0, 1'b0);
        check_val("t61_w1", 32'(d1), 32'h0101);
        check_val("t61_w0", 32'(d0), 32'h0101);
        check_val("t61_running", 32'(if_w0.running), 32'd1);
        pulse(1'b0, 1'b0, 1'b1);
        check_val("clr1_digits", 32'(d1), 32'h0000);
        check_val("clr1_running", 32'(if_w1.running), 32'd0);

        // Run up to 59:58, then across the boundary.
        pulse(1'b0, 1'b1, 1'b0);
        repeat (3598) pulse(1'b1, 1'b0, 1'b0);
        check_val("pre_w1", 32'(d1), 32'h5958);
        check_val("pre_w0", 32'(d0), 32'h5958);
        cc1 = 0; cc0 = 0;
        pulse(1'b1, 1'b0, 1'b0);
        check_val("max_w1", 32'(d1), 32'h5959);
        check_val("max_w0", 32'(d0), 32'h5959);
        check_val("max_carry_w1", 32'(cc1), 32'd0);
        pulse(1'b1, 1'b0, 1'b0);
        check_val("wrap_w1", 32'(d1), 32'h0000);
        check_val("wrap_run_w1", 32'(if_w1.running), 32'd1);
        check_val("wrap_carry_w1", 32'(cc1), 32'd1);
        check_val("hold_w0", 32'(d0), 32'h5959);
        check_val("hold_done_w0", 32'(if_w0.done), 32'd1);
        check_val("hold_run_w0", 32'(if_w0.running), 32'd0);
        check_val("hold_carry_w0", 32'(cc0), 32'd1);
        repeat (2) pulse(1'b1, 1'b0, 1'b0);
        check_val("after_w1", 32'(d1), 32'h0002);
        check_val("after_carry_w1", 32'(cc1), 32'd1);
        check_val("after_w0", 32'(d0), 32'h5959);
        check_val("after_carry_w0", 32'(cc0), 32'd1);
        pulse(1'b0, 1'b1, 1'b0);
        check_val("done_sp_done", 32'(if_w0.done), 32'd1);
        check_val("done_sp_run", 32'(if_w0.running), 32'd0);
        pulse(1'b0, 1'b0, 1'b1);
        check_val("clr2_w0", 32'(d0), 32'h0000);
        check_val("clr2_done", 32'(if_w0.done), 32'd0);
        check_val("clr2_run_w1", 32'(if_w1.running), 32'd0);

        // Pause with a coincident tick, ticks ignored while paused, resume.
        pulse(1'b0, 1'b1, 1'b0);
        repeat (5) pulse(1'b1, 1'b0, 1'b0);
        check_val("p_0005", 32'(d1), 32'h0005);
        pulse(1'b1, 1'b1, 1'b0);
        check_val("p_0006", 32'(d1), 32'h0006);
        check_val("p_paused", 32'(if_w1.running), 32'd0);
        repeat (5) pulse(1'b1, 1'b0, 1'b0);
        check_val("p_held", 32'(d0), 32'h0006);
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        check_val("p_0007", 32'(d1), 32'h0007);
        check_val("p_resumed", 32'(if_w1.running), 32'd1);
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b1, 1'b0);
        check_val("p_resume_tick", 32'(d1), 32'h0007);
        check_val("p_resume_run", 32'(if_w1.running), 32'd1);

        // Clear beats tick and start_pause.
        repeat (2) pulse(1'b1, 1'b0, 1'b0);
        check_val("c_0009", 32'(d1), 32'h0009);
        pulse(1'b1, 1'b1, 1'b1);
        check_val("c_digits", 32'(d1), 32'h0000);
        check_val("c_running", 32'(if_w1.running), 32'd0);
        pulse(1'b1, 1'b0, 1'b0);
        check_val("c_idle_tick", 32'(d1), 32'h0000);

        // Asynchronous reset between edges at 12:34.
        pulse(1'b0, 1'b1, 1'b0);
        repeat (754) pulse(1'b1, 1'b0, 1'b0);
        check_val("r_1234", 32'(d1), 32'h1234);
        #2;
        tick  = 1'b1;
        rst_n = 1'b0;
        #1;
        check_val("r_digits_w1", 32'(d1), 32'h0000);
        check_val("r_digits_w0", 32'(d0), 32'h0000);
        check_val("r_running", 32'(if_w1.running), 32'd0);
        check_val("r_carry", 32'(if_w1.carry_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        check_val("r_release", 32'(d1), 32'h0000);
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        check_val("r_first_tick", 32'(d1), 32'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_upcounter.md
STOPWATCH_UPCOUNTER -- requirements
Module: stopwatch_upcounter

Interface
REQ-001 Parameter: WRAP, default 1, 1 = wrap 59:59->00:00, 0 = stop at 59:59 and hold in DONE.
REQ-002 clk  input  1  single system clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 tick  input  1  count-enable pulse, one clk cycle wide (1 Hz strobe).
REQ-005 start_pause  input  1  one-cycle pulse, already debounced; toggles run/pause.
REQ-006 clear  input  1  one-cycle pulse; return to 00:00 and IDLE.
REQ-007 sec_ones  output  4  BCD seconds units, 0-9.
REQ-008 sec_tens  output  4  BCD seconds tens, 0-5.
REQ-009 min_ones  output  4  BCD minutes units, 0-9.
REQ-010 min_tens  output  4  BCD minutes tens, 0-5.
REQ-011 running  output  1  high while state is RUN.
REQ-012 done  output  1  high while state is DONE (WRAP=0 only).
REQ-013 carry_out  output  1  combinational; high in the cycle a counted tick rolls 59:59 over (WRAP=1) or reaches DONE (WRAP=0).

Function
REQ-014 States: IDLE, RUN, PAUSE, DONE; registered state, digits registered.
REQ-015 IDLE + start_pause -> RUN; RUN + start_pause -> PAUSE; PAUSE + start_pause -> RUN; DONE ignores start_pause.
REQ-016 clear in any state -> IDLE and all digits 0 on next edge; clear overrides tick and start_pause in the same cycle.
REQ-017 A tick is counted only when current state is RUN; tick coincident with start_pause in RUN is counted (pause takes effect next cycle); tick coincident with start_pause in IDLE/PAUSE is not counted.
REQ-018 Counted tick increments sec_ones; each digit at its limit (9,5,9,5) returns to 0 and carries into the next digit in the same cycle; latency one clk from tick to updated digits.
REQ-019 Carry chain is combinational across all four digits; 59:59 + counted tick updates all four digits on one edge.
REQ-020 WRAP=1: 59:59 + counted tick -> 00:00, state stays RUN, carry_out high that cycle.
REQ-021 WRAP=0: 59:59 is held; the counted tick arriving at 59:59 leaves digits at 59:59, moves state to DONE, carry_out high that cycle; only clear leaves DONE.
REQ-022 Digits never hold non-BCD or out-of-limit values; no tick ever skips or double-counts.
REQ-023 Digits hold their value in PAUSE and DONE; PAUSE -> RUN resumes from held value.

Reset
REQ-024 rst_n low asynchronously forces state IDLE, all digits 0, running 0, done 0; carry_out 0 while in reset.
REQ-025 Reset asserted mid-count discards the count; first counted tick after release and start_pause yields 00:01.
REQ-026 Release of rst_n is synchronous to clk; no counting in the release cycle.

Structure
REQ-027 Shared package holds state encoding (2 bits) and digit limit constants (9 for ones, 5 for tens).
REQ-028 One sub-module, upcounter: one BCD digit with increase, limit, carry, clk, rst_n; instantiated four times, carry of each driving increase of the next.
REQ-029 FSM and WRAP/DONE logic live in the top; upcounter has no knowledge of states.

Verification
REQ-030 Reset, start_pause, 61 ticks -> display 01:01, running=1.
REQ-031 Preload to 59:58 via ticks, WRAP=1, two ticks -> 59:59 then 00:00, carry_out pulsed once, running=1.
REQ-032 WRAP=0, reach 59:59, 3 further ticks -> digits 59:59, done=1, running=0; start_pause ignored; clear -> 00:00 IDLE.
REQ-033 RUN at 00:05, start_pause+tick same cycle -> 00:06 and PAUSE; 5 ticks -> 00:06; start_pause, 1 tick -> 00:07.
REQ-034 RUN at 00:09, clear+tick+start_pause same cycle -> 00:00, IDLE, running=0.
REQ-035 rst_n pulsed low asynchronously (between edges) at 12:34 -> outputs 00:00 immediately, IDLE.
